// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared types and constants for the decoder address sequencer.
// Build option: STEP_SYNC_EN (see decoder_scan_ctrl.sv).
package decoder_scan_pkg;

    localparam int unsigned ADDR_W      = 4;
    localparam logic [ADDR_W-1:0] ADDR_MAX = 4'd15;
    localparam int unsigned DIV_DEFAULT = 25_000_000;
    localparam int unsigned DIV_SIM     = 4;

    typedef enum logic {
        B_UP   = 1'b0,
        B_DOWN = 1'b1
    } bounce_state_e;

endpackage

// File: rtl/decoder_scan_ctrl_if.sv
// Control and decoder-select bundle between the sequencer and its user.
interface decoder_scan_ctrl_if import decoder_scan_pkg::*; ();

    logic              run;
    logic              dir;
    logic              mode;
    logic              step;
    logic              blank;
    logic [ADDR_W-1:0] addr_o;
    logic              en_o;
    logic              tick_o;

    modport master (
        output run, dir, mode, step, blank,
        input  addr_o, en_o, tick_o
    );

    modport slave (
        input  run, dir, mode, step, blank,
        output addr_o, en_o, tick_o
    );

endinterface

// File: rtl/decoder_scan_ctrl_prescaler.sv
// Free-running divider: one-cycle tick every DIV clocks while run is high.
module tick_prescaler #(
    parameter int unsigned DIV   = 25_000_000,
    parameter int unsigned DIV_W = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] cnt;

    assign tick = run && (cnt == LAST);

    // Stopping clears the count so a restart always waits a full DIV period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Address sequencer feeding a 4-to-16 decoder: wrap/bounce scan, single-step, blanking.
// Build option: define STEP_SYNC_EN to pass step through a 2-flop synchronizer.
module decoder_scan_ctrl import decoder_scan_pkg::*; #(
    parameter int unsigned DIV   = DIV_DEFAULT,
    parameter int unsigned DIV_W = 25
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_scan_ctrl_if.slave   bus
);

    logic              tick;
    logic              step_s;
    logic              step_q;
    logic              step_adv;
    logic              adv;
    logic              mode_q;
    logic              entering;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;
    logic              en_q;
    logic              tick_q;
    bounce_state_e     b_state;
    bounce_state_e     b_entry;
    bounce_state_e     b_cur;
    bounce_state_e     b_next;

    tick_prescaler #(.DIV(DIV), .DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .run  (bus.run),
        .tick (tick)
    );

`ifdef STEP_SYNC_EN
    logic [1:0] step_sync;

    always_ff @(posedge clk) begin
        if (rst) step_sync <= '0;
        else     step_sync <= {step_sync[0], bus.step};
    end

    assign step_s = step_sync[1];
`else
    assign step_s = bus.step;
`endif

    assign step_adv = step_s && !step_q && !bus.run;
    assign adv      = tick || step_adv;
    assign entering = bus.mode && !mode_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        b_entry   = bus.dir ? B_DOWN : B_UP;
        if (addr_q == ADDR_MAX) b_entry = B_DOWN;
        if (addr_q == '0)       b_entry = B_UP;
        b_cur     = entering ? b_entry : b_state;
        b_next    = bus.mode ? b_cur : b_state;
        addr_next = addr_q;
        if (adv) begin
            if (bus.mode) begin
                if (b_cur == B_UP) begin
                    addr_next = addr_q + 4'd1;
                    if (addr_next == ADDR_MAX) b_next = B_DOWN;
                end else begin
                    addr_next = addr_q - 4'd1;
                    if (addr_next == '0) b_next = B_UP;
                end
            end else begin
                addr_next = bus.dir ? addr_q - 4'd1 : addr_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) b_state <= B_UP;
        else     b_state <= b_next;
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            tick_q <= 1'b0;
            en_q   <= 1'b0;
            step_q <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            addr_q <= addr_next;
            tick_q <= adv;
            en_q   <= !bus.blank;
            step_q <= step_s;
            mode_q <= bus.mode;
        end
    end

    assign bus.addr_o = addr_q;
    assign bus.en_o   = en_q;
    assign bus.tick_o = tick_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: per-cycle vector table plus free-run scan sequences.
module tb_decoder_scan_ctrl;
    import decoder_scan_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    decoder_scan_ctrl_if bus();

    decoder_scan_ctrl #(.DIV(DIV_SIM), .DIV_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, run, dir, mode, step, blank;
        logic [3:0] addr;
        logic       en, tick;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic ru, input logic d, input logic m,
                                input logic s, input logic b, input logic [3:0] a,
                                input logic e, input logic t);
        vec_t v;
        v = '{r, ru, d, m, s, b, a, e, t};
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic d, input logic m,
                         input logic s, input logic b);
        rst = r; bus.run = ru; bus.dir = d; bus.mode = m; bus.step = s; bus.blank = b;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0);

        //   rst run dir mode step blank   addr en tick
        add(1, 0, 0, 0, 0, 0,  4'd0,  0, 0);
        add(1, 0, 0, 0, 0, 0,  4'd0,  0, 0);
        add(0, 0, 0, 0, 0, 0,  4'd0,  1, 0);
        add(0, 0, 0, 0, 1, 0,  4'd1,  1, 1);   // step edge
        add(0, 0, 0, 0, 1, 0,  4'd1,  1, 0);   // held high: no repeat
        add(0, 0, 0, 0, 0, 0,  4'd1,  1, 0);
        add(0, 0, 1, 0, 1, 0,  4'd0,  1, 1);   // wrap down
        add(0, 0, 1, 0, 0, 0,  4'd0,  1, 0);
        add(0, 0, 1, 0, 1, 0,  4'd15, 1, 1);   // 0 -> 15
        add(0, 0, 1, 0, 0, 0,  4'd15, 1, 0);
        add(0, 0, 0, 0, 1, 0,  4'd0,  1, 1);   // 15 -> 0
        add(0, 0, 0, 0, 0, 0,  4'd0,  1, 0);
        add(0, 0, 1, 1, 0, 0,  4'd0,  1, 0);   // enter bounce at 0 with dir=1 -> B_UP
        add(0, 0, 1, 1, 1, 0,  4'd1,  1, 1);
        add(0, 0, 0, 1, 0, 0,  4'd1,  1, 0);
        add(0, 0, 0, 1, 1, 0,  4'd2,  1, 1);
        add(0, 0, 1, 0, 0, 0,  4'd2,  1, 0);
        add(0, 0, 1, 0, 1, 0,  4'd1,  1, 1);
        add(0, 0, 1, 0, 0, 0,  4'd1,  1, 0);
        add(0, 0, 1, 0, 1, 0,  4'd0,  1, 1);
        add(0, 0, 1, 0, 0, 0,  4'd0,  1, 0);
        add(0, 0, 1, 0, 1, 0,  4'd15, 1, 1);
        add(0, 0, 0, 1, 0, 0,  4'd15, 1, 0);   // enter bounce at 15 with dir=0 -> B_DOWN
        add(0, 0, 0, 1, 1, 0,  4'd14, 1, 1);
        add(0, 0, 0, 1, 0, 0,  4'd14, 1, 0);
        add(0, 0, 0, 1, 1, 0,  4'd13, 1, 1);
        add(0, 0, 0, 1, 0, 1,  4'd13, 0, 0);   // blank
        add(0, 0, 0, 1, 1, 1,  4'd12, 0, 1);
        add(0, 0, 0, 1, 0, 0,  4'd12, 1, 0);
        add(1, 0, 0, 1, 0, 0,  4'd0,  0, 0);   // reset mid-bounce (B_DOWN)
        add(0, 0, 0, 1, 1, 0,  4'd1,  1, 1);   // resumes in B_UP
        add(0, 0, 0, 1, 0, 0,  4'd1,  1, 0);
        add(0, 0, 0, 1, 1, 0,  4'd2,  1, 1);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].run, vecs[i].dir, vecs[i].mode, vecs[i].step, vecs[i].blank);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d addr", i), int'(bus.addr_o), int'(vecs[i].addr));
            check($sformatf("vec%0d en", i),   int'(bus.en_o),   int'(vecs[i].en));
            check($sformatf("vec%0d tick", i), int'(bus.tick_o), int'(vecs[i].tick));
        end

        // Free-run wrap up from reset; step toggling must be ignored while running.
        drive(1, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        drive(0, 1, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            for (int c = 1; c <= 4; c++) begin
                bus.step = c[0];
                @(posedge clk);
                @(negedge clk);
                check($sformatf("wrap k%0d c%0d addr", k, c), int'(bus.addr_o),
                      (c == 4) ? (k % 16) : ((k - 1) % 16));
                check($sformatf("wrap k%0d c%0d tick", k, c), int'(bus.tick_o), (c == 4) ? 1 : 0);
                check($sformatf("wrap k%0d c%0d en", k, c), int'(bus.en_o), 1);
            end
        end

        // Free-run bounce from addr 0: 1..15, 14..0, 1, 2.
        bus.step = 1'b0;
        bus.mode = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            for (int c = 1; c <= 4; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (c == 4) begin
                    int pos;
                    pos = k % 30;
                    check($sformatf("bounce k%0d addr", k), int'(bus.addr_o),
                          (pos <= 15) ? pos : (30 - pos));
                end
                check($sformatf("bounce k%0d c%0d tick", k, c), int'(bus.tick_o), (c == 4) ? 1 : 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
